// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states,
// interrupt cause codes, mcause encodings and the CSR addresses they relate to.
// Pure definitions; no timing or flow control.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    TRAP  = 2'd2,
    RET   = 2'd3
  } trap_state_t;

  // Machine-level interrupt cause codes (mcause low bits)
  localparam logic [4:0] IRQ_M_EXT   = 5'd11;
  localparam logic [4:0] IRQ_M_TIMER = 5'd7;

  // CSR addresses touched by the trap/return sequence
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mcause for an interrupt: MSB set, cause code in the low bits
  function automatic logic [31:0] irq_cause(input logic [4:0] code);
    return {1'b1, 26'd0, code};
  endfunction

  localparam logic [31:0] CAUSE_M_EXT   = irq_cause(IRQ_M_EXT);
  localparam logic [31:0] CAUSE_M_TIMER = irq_cause(IRQ_M_TIMER);

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: STAGES clk cycles from d to q.
// No backpressure; level in, level out.
// Ports: clk, rst (async active-low), d (async level), q (synchronized level).
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/return/WFI sequencer: takes interrupts, MRET and WFI at commit.
// Latency: event sampled on an unstalled cycle N pulses in N+1 (ext_irq +SYNC_STAGES).
// Backpressure: pc_stall freezes the FSM and suppresses every pulse output.
// Ports: clk, rst (async active-low); ext_irq/timer_irq interrupt levels;
//   csr_mie/csr_meie/csr_mtie/csr_mepc from the CSR file; wfi_req/mret_req/cur_pc
//   from commit; pc_stall; outputs meip/mtip, trap_take/mret_take + trap_epc/
//   trap_cause to the CSR file, redirect_valid/redirect_pc/flush/halt to fetch.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RST   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        csr_mie,
  input  logic        csr_meie,
  input  logic        csr_mtie,
  input  logic [31:0] csr_mepc,
  input  logic        wfi_req,
  input  logic        mret_req,
  input  logic [31:0] cur_pc,
  input  logic        pc_stall,
  output logic        meip,
  output logic        mtip,
  output logic        trap_take,
  output logic        mret_take,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_cause,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        halt
);

  trap_state_t state, state_n;
  logic [31:0] epc_q, epc_n;
  logic [31:0] cause_q, cause_n;
  logic [31:0] wfi_pc_q, wfi_pc_n;
  // blank_q: first RUN cycle after TRAP/RET, lets the CSR file's MIE update land
  // resume_q: first RUN cycle after a non-trapping wake from WFI; carries the redirect
  logic        blank_q, blank_n;
  logic        resume_q, resume_n;

  logic        ext_pend;
  logic        pend;
  logic [31:0] cause_sel;

  irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_irq),
    .q   (meip)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtip     <= 1'b0;
      state    <= RUN;
      epc_q    <= '0;
      cause_q  <= '0;
      wfi_pc_q <= '0;
      blank_q  <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      mtip     <= timer_irq;
      state    <= state_n;
      epc_q    <= epc_n;
      cause_q  <= cause_n;
      wfi_pc_q <= wfi_pc_n;
      blank_q  <= blank_n;
      resume_q <= resume_n;
    end
  end

  assign ext_pend  = meip & csr_meie;
  assign pend      = ext_pend | (mtip & csr_mtie);
  assign cause_sel = ext_pend ? CAUSE_M_EXT : CAUSE_M_TIMER;

  always_comb begin
    state_n        = state;
    epc_n          = epc_q;
    cause_n        = cause_q;
    wfi_pc_n       = wfi_pc_q;
    blank_n        = blank_q;
    resume_n       = resume_q;
    trap_take      = 1'b0;
    mret_take      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Target PC is presented whenever the state implies a redirect;
    // the pulses themselves are gated by pc_stall.
    unique case (state)
      TRAP:    redirect_pc = MTVEC_RST;
      RET:     redirect_pc = csr_mepc;
      RUN:     if (resume_q) redirect_pc = wfi_pc_q + 32'd4;
      default: ;
    endcase

    if (!pc_stall) begin
      unique case (state)
        RUN: begin
          blank_n  = 1'b0;
          resume_n = 1'b0;
          redirect_valid = resume_q;
          if (!blank_q && !resume_q) begin
            if (pend && csr_mie) begin
              state_n = TRAP;
              // A WFI committing alongside the interrupt has retired: resume after it
              epc_n   = wfi_req ? cur_pc + 32'd4 : cur_pc;
              cause_n = cause_sel;
            end else if (mret_req) begin
              state_n = RET;
            end else if (wfi_req) begin
              state_n  = SLEEP;
              wfi_pc_n = cur_pc;
            end
          end
        end
        SLEEP: begin
          // Wake on any enabled pending source regardless of global MIE
          if (pend) begin
            if (csr_mie) begin
              state_n = TRAP;
              epc_n   = wfi_pc_q + 32'd4;
              cause_n = cause_sel;
            end else begin
              state_n  = RUN;
              resume_n = 1'b1;
            end
          end
        end
        TRAP: begin
          trap_take      = 1'b1;
          redirect_valid = 1'b1;
          state_n        = RUN;
          blank_n        = 1'b1;
        end
        RET: begin
          mret_take      = 1'b1;
          redirect_valid = 1'b1;
          state_n        = RUN;
          blank_n        = 1'b1;
        end
        default: state_n = RUN;
      endcase
    end

    flush = redirect_valid;
    halt  = (state == SLEEP);
  end

  assign trap_epc   = epc_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq, timer_irq;
  logic        csr_mie, csr_meie, csr_mtie;
  logic [31:0] csr_mepc;
  logic        wfi_req, mret_req;
  logic [31:0] cur_pc;
  logic        pc_stall;
  logic        meip, mtip, trap_take, mret_take;
  logic [31:0] trap_epc, trap_cause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush, halt;

  int checks = 0;
  int failures = 0;

  trap_ctrl #(.SYNC_STAGES(2), .MTVEC_RST(32'h0001_0000)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .csr_mie(csr_mie), .csr_meie(csr_meie), .csr_mtie(csr_mtie),
    .csr_mepc(csr_mepc), .wfi_req(wfi_req), .mret_req(mret_req),
    .cur_pc(cur_pc), .pc_stall(pc_stall), .meip(meip), .mtip(mtip),
    .trap_take(trap_take), .mret_take(mret_take), .trap_epc(trap_epc),
    .trap_cause(trap_cause), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ext_irq = 0; timer_irq = 0; csr_mie = 0; csr_meie = 0; csr_mtie = 0;
    csr_mepc = 0; wfi_req = 0; mret_req = 0; cur_pc = 0; pc_stall = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 0;
    idle(3);
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_halt got=%0b exp=0", halt); end
    checks++; if (trap_take !== 1'b0 || mret_take !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%0b%0b%0b%0b exp=0000", trap_take, mret_take, redirect_valid, flush); end
    checks++; if (meip !== 1'b0 || mtip !== 1'b0) begin failures++; $display("FAIL rst_pending got=%0b%0b exp=00", meip, mtip); end
    checks++; if (trap_epc !== 32'h0 || trap_cause !== 32'h0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_data got=%h/%h/%h exp=0/0/0", trap_epc, trap_cause, redirect_pc); end
    rst = 1;
    idle(2);
  endtask

  // External interrupt through a 2-flop synchronizer: pulse 3 edges after ext_irq rises
  task automatic test_ext_irq();
    csr_mie = 1; csr_meie = 1; cur_pc = 32'h100;
    ext_irq = 1;
    tick();
    checks++; if (trap_take !== 1'b0) begin failures++; $display("FAIL ext_early1 got=%0b exp=0", trap_take); end
    tick();
    checks++; if (meip !== 1'b1 || trap_take !== 1'b0) begin failures++; $display("FAIL ext_early2 meip=%0b trap=%0b exp=1/0", meip, trap_take); end
    tick();
    checks++; if (trap_take !== 1'b1 || flush !== 1'b1 || redirect_valid !== 1'b1) begin failures++; $display("FAIL ext_pulse got=%0b%0b%0b exp=111", trap_take, flush, redirect_valid); end
    checks++; if (redirect_pc !== 32'h0001_0000) begin failures++; $display("FAIL ext_rpc got=%h exp=00010000", redirect_pc); end
    checks++; if (trap_cause !== 32'h8000_000B) begin failures++; $display("FAIL ext_cause got=%h exp=8000000b", trap_cause); end
    checks++; if (trap_epc !== 32'h100) begin failures++; $display("FAIL ext_epc got=%h exp=00000100", trap_epc); end
    tick();
    checks++; if (trap_take !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL ext_after got=%0b%0b exp=00", trap_take, redirect_valid); end
    // Still pending and enabled: the blanking cycle must prevent an immediate retake
    tick();
    checks++; if (trap_take !== 1'b0) begin failures++; $display("FAIL ext_blank got=%0b exp=0", trap_take); end
    idle(5);
  endtask

  // WFI with MIE=0: timer wakes and resumes at pc+4 without a trap
  task automatic test_wfi_resume();
    int halt_bad;
    csr_mie = 0; csr_mtie = 1; wfi_req = 1; cur_pc = 32'h200;
    tick();
    wfi_req = 0; cur_pc = 32'h999;
    halt_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (halt !== 1'b1 || redirect_valid !== 1'b0) halt_bad++;
      tick();
    end
    checks++; if (halt_bad != 0) begin failures++; $display("FAIL wfi_halt bad_cycles=%0d exp=0", halt_bad); end
    timer_irq = 1;
    tick();
    checks++; if (halt !== 1'b1 || redirect_valid !== 1'b0) begin failures++; $display("FAIL wfi_wait halt=%0b rv=%0b exp=1/0", halt, redirect_valid); end
    tick();
    checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h204) begin failures++; $display("FAIL wfi_resume rv=%0b fl=%0b rpc=%h exp=1/1/00000204", redirect_valid, flush, redirect_pc); end
    checks++; if (trap_take !== 1'b0 || halt !== 1'b0) begin failures++; $display("FAIL wfi_notrap trap=%0b halt=%0b exp=0/0", trap_take, halt); end
    tick();
    checks++; if (redirect_valid !== 1'b0 || trap_take !== 1'b0) begin failures++; $display("FAIL wfi_after rv=%0b trap=%0b exp=0/0", redirect_valid, trap_take); end
    idle(4);
  endtask

  // WFI at top of address space, woken with MIE=1: trap with epc wrapping to 0
  task automatic test_wfi_wrap();
    csr_mie = 1; csr_mtie = 1; wfi_req = 1; cur_pc = 32'hFFFF_FFFC;
    tick();
    wfi_req = 0; timer_irq = 1;
    tick();
    checks++; if (trap_take !== 1'b0 || halt !== 1'b1) begin failures++; $display("FAIL wrap_wait trap=%0b halt=%0b exp=0/1", trap_take, halt); end
    tick();
    checks++; if (trap_take !== 1'b1 || trap_epc !== 32'h0 || trap_cause !== 32'h8000_0007) begin failures++; $display("FAIL wrap_trap trap=%0b epc=%h cause=%h exp=1/00000000/80000007", trap_take, trap_epc, trap_cause); end
    idle(4);
  endtask

  // Interrupt coincident with WFI at commit: epc points after the WFI
  task automatic test_wfi_irq();
    csr_mtie = 1; timer_irq = 1;
    tick(); tick();
    csr_mie = 1; wfi_req = 1; cur_pc = 32'h500;
    tick();
    checks++; if (trap_take !== 1'b1 || trap_epc !== 32'h504 || halt !== 1'b0) begin failures++; $display("FAIL wfiirq trap=%0b epc=%h halt=%0b exp=1/00000504/0", trap_take, trap_epc, halt); end
    idle(4);
  endtask

  // Both sources pending plus MRET: one trap, external cause, no mret
  task automatic test_priority();
    ext_irq = 1; timer_irq = 1; csr_mie = 1;
    tick(); tick(); tick();
    csr_meie = 1; csr_mtie = 1; mret_req = 1; cur_pc = 32'h400; csr_mepc = 32'h300;
    tick();
    checks++; if (trap_take !== 1'b1 || mret_take !== 1'b0) begin failures++; $display("FAIL prio_take trap=%0b mret=%0b exp=1/0", trap_take, mret_take); end
    checks++; if (trap_cause !== 32'h8000_000B || trap_epc !== 32'h400) begin failures++; $display("FAIL prio_data cause=%h epc=%h exp=8000000b/00000400", trap_cause, trap_epc); end
    mret_req = 0; csr_mie = 0;
    tick();
    checks++; if (trap_take !== 1'b0 || mret_take !== 1'b0) begin failures++; $display("FAIL prio_after trap=%0b mret=%0b exp=0/0", trap_take, mret_take); end
    idle(5);
  endtask

  // MRET held across a 3-cycle stall: nothing during stall, pulse after release
  task automatic test_mret_stall();
    int bad;
    csr_mepc = 32'h300; mret_req = 1; pc_stall = 1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mret_take !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_quiet bad_cycles=%0d exp=0", bad); end
    pc_stall = 0;
    tick();
    checks++; if (mret_take !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin failures++; $display("FAIL stall_mret mret=%0b rv=%0b rpc=%h exp=1/1/00000300", mret_take, redirect_valid, redirect_pc); end
    checks++; if (trap_take !== 1'b0) begin failures++; $display("FAIL stall_notrap got=%0b exp=0", trap_take); end
    mret_req = 0;
    tick();
    checks++; if (mret_take !== 1'b0) begin failures++; $display("FAIL stall_after got=%0b exp=0", mret_take); end
    idle(3);
  endtask

  // Reset mid-SLEEP: halt drops at once, no wake redirect afterwards, back in RUN
  task automatic test_reset_sleep();
    int bad;
    csr_mie = 0; csr_mtie = 1; wfi_req = 1; cur_pc = 32'h600;
    tick();
    wfi_req = 0;
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL rsl_sleep got=%0b exp=1", halt); end
    timer_irq = 1;
    #2 rst = 0;
    #1;
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rsl_halt got=%0b exp=0", halt); end
    tick(); tick();
    rst = 1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (redirect_valid !== 1'b0 || halt !== 1'b0 || trap_take !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rsl_quiet bad_cycles=%0d exp=0", bad); end
    mret_req = 1; csr_mepc = 32'h700;
    tick();
    checks++; if (mret_take !== 1'b1 || redirect_pc !== 32'h700) begin failures++; $display("FAIL rsl_run mret=%0b rpc=%h exp=1/00000700", mret_take, redirect_pc); end
    idle(3);
  endtask

  initial begin
    rst = 0;
    test_reset();
    test_ext_irq();
    test_wfi_resume();
    test_wfi_wrap();
    test_wfi_irq();
    test_priority();
    test_mret_stall();
    test_reset_sleep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops in the external-interrupt synchronizer (legal range 2..4).
REQ-002 Parameter MTVEC_RST, default 32'h0001_0000, trap vector used for every trap.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserts immediately; deasserts synchronously to clk).
REQ-005 ext_irq  input  1  raw external interrupt line, asynchronous to clk, level-sensitive.
REQ-006 timer_irq  input  1  timer interrupt level, synchronous to clk.
REQ-007 csr_mie  input  1  mstatus.MIE from the CSR file.
REQ-008 csr_meie, csr_mtie  input  1 each  mie.MEIE / mie.MTIE from the CSR file.
REQ-009 csr_mepc  input  32  current mepc from the CSR file.
REQ-010 wfi_req, mret_req  input  1 each  WFI / MRET reaching the commit stage this cycle.
REQ-011 cur_pc  input  32  PC of the instruction at the commit stage.
REQ-012 pc_stall  input  1  pipeline frozen by a bus wait; no commit this cycle.
REQ-013 meip, mtip  output  1 each  mip pending bits (synchronized external; registered timer).
REQ-014 trap_take  output  1  one-cycle pulse; CSR file saves MIE->MPIE, clears MIE, sets MPP=2'b11.
REQ-015 mret_take  output  1  one-cycle pulse; CSR file restores MIE from MPIE.
REQ-016 trap_epc  output  32  mepc value to save, valid with trap_take.
REQ-017 trap_cause  output  32  mcause value, valid with trap_take.
REQ-018 redirect_valid  output  1  one-cycle pulse; fetch restarts at redirect_pc.
REQ-019 redirect_pc  output  32  new fetch PC, valid with redirect_valid.
REQ-020 flush  output  1  one-cycle pulse, coincident with redirect_valid; kills younger instructions.
REQ-021 halt  output  1  high while sleeping in WFI; freezes fetch.

Function
REQ-022 ext_irq SHALL pass through SYNC_STAGES flops; meip is the last stage; mtip is timer_irq registered once.
REQ-023 pend SHALL be (meip & csr_meie) | (mtip & csr_mtie); cause SHALL be 32'h8000_000B when meip & csr_meie, else 32'h8000_0007 (external wins).
REQ-024 FSM states SHALL be RUN, SLEEP, TRAP, RET; reset state RUN.
REQ-025 While pc_stall=1 the FSM SHALL hold state and all pulse outputs SHALL be 0; pending events are evaluated on the first unstalled cycle.
REQ-026 RUN: pend & csr_mie -> TRAP with epc=cur_pc; else mret_req -> RET; else wfi_req -> SLEEP; else stay.
REQ-027 Priority on simultaneous events: interrupt > mret_req > wfi_req; a wfi_req coinciding with a taken interrupt SHALL use epc=cur_pc+4.
REQ-028 SLEEP: halt=1; on pend (ignoring csr_mie): if csr_mie -> TRAP with epc=WFI pc+4, else -> RUN with redirect to WFI pc+4 (resume, no trap).
REQ-029 TRAP: single cycle; assert trap_take, redirect_valid, flush, redirect_pc=MTVEC_RST, trap_epc, trap_cause; -> RUN.
REQ-030 RET: single cycle; assert mret_take, redirect_valid, flush, redirect_pc=csr_mepc; -> RUN.
REQ-031 Latency: event sampled in cycle N (unstalled) SHALL produce pulses in cycle N+1; ext_irq adds SYNC_STAGES cycles.
REQ-032 PC arithmetic SHALL be 32-bit modulo (32'hFFFF_FFFC+4 wraps to 0).
REQ-033 No new trap SHALL be taken in the cycle after TRAP/RET (one RUN cycle of blanking) so csr_mie updates are seen.

Reset
REQ-034 On rst=0: state RUN, all synchronizer flops 0, meip=mtip=0, all pulses 0, halt=0, trap_epc=trap_cause=redirect_pc=0.
REQ-035 Reset asserted mid-SLEEP/TRAP/RET SHALL abort with no pulse emitted after release.

Structure
REQ-036 A shared package SHALL hold the state enum, mcause constants (IRQ_M_EXT=11, IRQ_M_TIMER=7) and CSR address constants.
REQ-037 The synchronizer SHALL be a sub-module irq_sync (parameter STAGES, async active-low reset).

Verification
REQ-038 csr_mie=1, csr_meie=1, ext_irq rises, cur_pc=0x100 -> trap_take, flush, redirect_pc=0x0001_0000, trap_cause=0x8000000B, trap_epc=0x100, exactly SYNC_STAGES+1 cycles later.
REQ-039 wfi_req at pc 0x200, csr_mie=0, csr_mtie=1, timer_irq after 10 cycles -> halt high 10+ cycles, then redirect_pc=0x204, no trap_take.
REQ-040 meip and mtip both pending and enabled, mret_req same cycle -> one trap_take with cause 0x8000000B, no mret_take.
REQ-041 mret_req with csr_mepc=0x300, pc_stall=1 for 3 cycles -> no pulses during stall; mret_take and redirect_pc=0x300 one cycle after stall release.
REQ-042 rst asserted during SLEEP -> halt=0 immediately, no redirect after release, state RUN.
